// File: rtl/adaptive_threshold_ctrl.sv
// adaptive_threshold_ctrl
// Closed-loop controller for the keypoint filter threshold. It counts
// keypoint strobes in each frame window. When the frame ends it compares
// the total against a band chosen by mode, then moves a signed threshold
// toward that band. Each move in the same direction doubles the step, up
// to STEP_MAX. The threshold is clamped to [TH_MIN, TH_MAX].
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   adapt_en      1 = adapt, 0 = force TH_INIT at each update
//   mode          0: 500..1000, 1: 1500..2000, 2/3: lo_cfg..hi_cfg
//   lo_cfg/hi_cfg programmable band bounds
//   frame_start   opens (or restarts) the counting window
//   frame_end     closes the window (the frame_end cycle is still counted)
//   kp_valid      one keypoint per cycle
//   threshold     current signed filter threshold
//   thr_valid     one-cycle pulse when threshold/last_count refresh
//   last_count    keypoint total of the last completed frame (saturating)
//   at_limit      threshold sits on TH_MIN or TH_MAX
//   busy          counting window open
//
// state  | meaning
// IDLE   | waiting for frame_start
// COUNT  | counting kp_valid strobes
// UPDATE | one cycle: evaluate band, step and clamp, then register results
module adaptive_threshold_ctrl #(
    parameter int TH_W     = 10,
    parameter int CNT_W    = 12,
    parameter int TH_INIT  = 2,
    parameter int TH_MIN   = 0,
    parameter int TH_MAX   = 511,
    parameter int STEP_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adapt_en,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        lo_cfg,
    input  logic [CNT_W-1:0]        hi_cfg,
    input  logic                    frame_start,
    input  logic                    frame_end,
    input  logic                    kp_valid,
    output logic signed [TH_W-1:0]  threshold,
    output logic                    thr_valid,
    output logic [CNT_W-1:0]        last_count,
    output logic                    at_limit,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, COUNT, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    localparam logic signed [TH_W-1:0] TH_INIT_V = TH_W'(TH_INIT);
    localparam logic signed [TH_W-1:0] TH_MIN_V  = TH_W'(TH_MIN);
    localparam logic signed [TH_W-1:0] TH_MAX_V  = TH_W'(TH_MAX);
    localparam logic signed [TH_W:0]   TH_MIN_X  = (TH_W+1)'(TH_MIN);
    localparam logic signed [TH_W:0]   TH_MAX_X  = (TH_W+1)'(TH_MAX);
    localparam logic [TH_W-1:0]        STEP_V    = TH_W'(STEP_MAX);
    localparam logic [TH_W:0]          STEP_X    = (TH_W+1)'(STEP_MAX);
    localparam logic                   INIT_LIM  = (TH_INIT == TH_MIN) || (TH_INIT == TH_MAX);

    state_t state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [TH_W-1:0]  step;
    dir_t             prev_dir;

    logic [CNT_W-1:0]       band_lo, band_hi;
    logic                   below, above;
    dir_t                   dir;
    logic [TH_W:0]          step_x2;
    logic [TH_W-1:0]        step_nxt;
    dir_t                   prev_nxt;
    logic signed [TH_W:0]   th_sum;
    logic signed [TH_W-1:0] th_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = COUNT;
            COUNT:   if (frame_end)   state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == COUNT);

    // Saturating count; no wrap at full scale.
    assign count_inc = (kp_valid && (count != '1)) ? count + 1'b1 : count;

    always_comb begin
        band_lo  = lo_cfg;
        band_hi  = hi_cfg;
        dir      = DIR_NONE;
        step_nxt = TH_W'(1);
        prev_nxt = DIR_NONE;
        th_sum   = {threshold[TH_W-1], threshold};
        th_nxt   = threshold;
        step_x2  = {step, 1'b0};

        case (mode)
            2'd0: begin
                band_lo = CNT_W'(500);
                band_hi = CNT_W'(1000);
            end
            2'd1: begin
                band_lo = CNT_W'(1500);
                band_hi = CNT_W'(2000);
            end
            default: begin
                band_lo = lo_cfg;
                band_hi = hi_cfg;
            end
        endcase

        below = (count < band_lo);
        above = (count > band_hi);
        // An inverted band can make both true; that case holds.
        if (below && !above)      dir = DIR_DOWN;
        else if (above && !below) dir = DIR_UP;
        else                      dir = DIR_NONE;

        if (dir != DIR_NONE) begin
            if (dir == prev_dir)
                step_nxt = (step_x2 > STEP_X) ? STEP_V : step_x2[TH_W-1:0];
            else
                step_nxt = TH_W'(1);
            prev_nxt = dir;
            // One extra bit so the out-of-range result is visible before clamping.
            if (dir == DIR_UP)
                th_sum = {threshold[TH_W-1], threshold} + {1'b0, step_nxt};
            else
                th_sum = {threshold[TH_W-1], threshold} - {1'b0, step_nxt};
            if (th_sum < TH_MIN_X)      th_nxt = TH_MIN_V;
            else if (th_sum > TH_MAX_X) th_nxt = TH_MAX_V;
            else                        th_nxt = th_sum[TH_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            step       <= TH_W'(1);
            prev_dir   <= DIR_NONE;
            threshold  <= TH_INIT_V;
            thr_valid  <= 1'b0;
            last_count <= '0;
            at_limit   <= INIT_LIM;
        end else begin
            thr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) count <= '0;
                end
                COUNT: begin
                    // frame_end takes priority over a simultaneous restart.
                    if (frame_end)        count <= count_inc;
                    else if (frame_start) count <= '0;
                    else                  count <= count_inc;
                end
                UPDATE: begin
                    last_count <= count;
                    thr_valid  <= 1'b1;
                    if (adapt_en) begin
                        threshold <= th_nxt;
                        step      <= step_nxt;
                        prev_dir  <= prev_nxt;
                        at_limit  <= (th_nxt == TH_MIN_V) || (th_nxt == TH_MAX_V);
                    end else begin
                        threshold <= TH_INIT_V;
                        step      <= TH_W'(1);
                        prev_dir  <= DIR_NONE;
                        at_limit  <= INIT_LIM;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adaptive_threshold_ctrl.sv
module tb_adaptive_threshold_ctrl;

    logic        clk = 1'b0;
    logic        rst, adapt_en, frame_start, frame_end, kp_valid;
    logic [1:0]  mode;
    logic [11:0] lo_cfg, hi_cfg;
    logic signed [9:0] threshold;
    logic        thr_valid, at_limit, busy;
    logic [11:0] last_count;

    adaptive_threshold_ctrl dut (
        .clk(clk), .rst(rst), .adapt_en(adapt_en), .mode(mode),
        .lo_cfg(lo_cfg), .hi_cfg(hi_cfg), .frame_start(frame_start),
        .frame_end(frame_end), .kp_valid(kp_valid), .threshold(threshold),
        .thr_valid(thr_valid), .last_count(last_count), .at_limit(at_limit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tv_cnt = 0;

    always @(posedge clk) if (thr_valid) tv_cnt++;

    // Reference model state: threshold, step, previous direction (+1/-1/0).
    int m_th, m_step, m_prev, m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_th = 2; m_step = 1; m_prev = 0; m_cnt = 0;
    endtask

    task automatic model_update(input int n, input int md, input int lo, input int hi, input bit en);
        int blo, bhi, dir;
        m_cnt = (n > 4095) ? 4095 : n;
        if (md == 0)      begin blo = 500;  bhi = 1000; end
        else if (md == 1) begin blo = 1500; bhi = 2000; end
        else              begin blo = lo;   bhi = hi;   end
        dir = 0;
        if (m_cnt < blo && !(m_cnt > bhi)) dir = -1;
        if (m_cnt > bhi && !(m_cnt < blo)) dir = 1;
        if (!en) begin
            m_th = 2; m_step = 1; m_prev = 0;
        end else if (dir == 0) begin
            m_step = 1; m_prev = 0;
        end else begin
            if (dir == m_prev) m_step = (2 * m_step > 16) ? 16 : 2 * m_step;
            else               m_step = 1;
            m_th = m_th + dir * m_step;
            if (m_th < 0)   m_th = 0;
            if (m_th > 511) m_th = 511;
            m_prev = dir;
        end
    endtask

    function automatic int m_lim();
        return (m_th == 0 || m_th == 511) ? 1 : 0;
    endfunction

    task automatic do_reset();
        rst = 1; adapt_en = 1; mode = 0; lo_cfg = 0; hi_cfg = 0;
        frame_start = 0; frame_end = 0; kp_valid = 0;
        tick(); tick();
        rst = 0;
        model_reset();
    endtask

    // One full frame of n keypoints; mode is scrambled while counting and
    // set to md only in the UPDATE cycle, where it is sampled.
    task automatic run_frame(input int n, input int md, input int lo, input int hi,
                             input bit en, input bit gaps);
        int prev_th;
        prev_th = m_th;
        lo_cfg = 12'(lo); hi_cfg = 12'(hi); adapt_en = en;
        mode = 2'($urandom_range(0, 3));
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("busy_count", int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                kp_valid = 0; tick();
            end
            kp_valid = 1;
            frame_end = (i == n - 1);
            tick();
        end
        if (n == 0) begin
            frame_end = 1; tick();
        end
        kp_valid = 0; frame_end = 0; mode = 2'(md);
        model_update(n, md, lo, hi, en);
        chk("tv_early", int'(thr_valid), 0);
        chk("th_stable", int'(threshold), prev_th);
        tick();
        chk("tv_pulse", int'(thr_valid), 1);
        chk("threshold", int'(threshold), m_th);
        chk("last_count", int'(last_count), m_cnt);
        chk("at_limit", int'(at_limit), m_lim());
        chk("busy_idle", int'(busy), 0);
        tick();
        chk("tv_end", int'(thr_valid), 0);
    endtask

    typedef struct {
        bit do_rst;
        int n;
        int md;
        int lo;
        int hi;
        bit en;
        int e_th;
        int e_cnt;
        int e_lim;
    } vec_t;

    vec_t vec[12];

    initial begin
        int tv0;
        vec[0]  = '{1, 300,  0, 0,   0,  1, 1,  300,  0};
        vec[1]  = '{1, 1200, 0, 0,   0,  1, 3,  1200, 0};
        vec[2]  = '{0, 1200, 0, 0,   0,  1, 5,  1200, 0};
        vec[3]  = '{0, 1200, 0, 0,   0,  1, 9,  1200, 0};
        vec[4]  = '{0, 700,  0, 0,   0,  1, 9,  700,  0};
        vec[5]  = '{0, 1200, 0, 0,   0,  1, 10, 1200, 0};
        vec[6]  = '{1, 100,  0, 0,   0,  1, 1,  100,  0};
        vec[7]  = '{0, 100,  0, 0,   0,  1, 0,  100,  1};
        vec[8]  = '{0, 100,  0, 0,   0,  1, 0,  100,  1};
        vec[9]  = '{0, 75,   2, 100, 50, 1, 0,  75,   1};
        vec[10] = '{0, 5000, 0, 0,   0,  1, 1,  4095, 0};
        vec[11] = '{0, 300,  0, 0,   0,  0, 2,  300,  0};

        do_reset();
        chk("rst_threshold", int'(threshold), 2);
        chk("rst_thr_valid", int'(thr_valid), 0);
        chk("rst_last_count", int'(last_count), 0);
        chk("rst_at_limit", int'(at_limit), 0);
        chk("rst_busy", int'(busy), 0);

        for (int i = 0; i < 12; i++) begin
            if (vec[i].do_rst) do_reset();
            run_frame(vec[i].n, vec[i].md, vec[i].lo, vec[i].hi, vec[i].en, 1'b0);
            chk($sformatf("vec%0d_th", i), int'(threshold), vec[i].e_th);
            chk($sformatf("vec%0d_cnt", i), int'(last_count), vec[i].e_cnt);
            chk($sformatf("vec%0d_lim", i), int'(at_limit), vec[i].e_lim);
        end

        // Climb to TH_MAX with one-keypoint frames against an empty band.
        do_reset();
        for (int i = 0; i < 40; i++) run_frame(1, 2, 0, 0, 1'b1, 1'b0);
        chk("max_th", int'(threshold), 511);
        chk("max_lim", int'(at_limit), 1);
        run_frame(3000, 0, 0, 0, 1'b1, 1'b0);
        chk("max_hold_th", int'(threshold), 511);
        chk("max_hold_lim", int'(at_limit), 1);

        // Restart mid-frame: only the last 10 keypoints count, one pulse.
        do_reset();
        tv0 = tv_cnt;
        mode = 0; adapt_en = 1;
        frame_start = 1; tick(); frame_start = 0;
        kp_valid = 1;
        for (int i = 0; i < 40; i++) tick();
        kp_valid = 0; frame_start = 1; tick(); frame_start = 0;
        chk("restart_busy", int'(busy), 1);
        kp_valid = 1;
        for (int i = 0; i < 10; i++) begin
            frame_end = (i == 9);
            tick();
        end
        kp_valid = 0; frame_end = 0;
        model_update(10, 0, 0, 0, 1'b1);
        tick(); tick();
        chk("restart_count", int'(last_count), 10);
        chk("restart_th", int'(threshold), m_th);
        chk("restart_pulses", tv_cnt - tv0, 1);

        // frame_start and frame_end together in COUNT: frame_end wins.
        tv0 = tv_cnt;
        frame_start = 1; tick(); frame_start = 0;
        kp_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        frame_start = 1; frame_end = 1; tick();
        frame_start = 0; frame_end = 0; kp_valid = 0;
        model_update(6, 0, 0, 0, 1'b1);
        tick(); tick();
        chk("both_count", int'(last_count), 6);
        chk("both_th", int'(threshold), m_th);
        chk("both_pulses", tv_cnt - tv0, 1);

        // frame_end in IDLE is ignored.
        tv0 = tv_cnt;
        kp_valid = 1; frame_end = 1; tick(); frame_end = 0; tick(); tick();
        kp_valid = 0;
        chk("idle_end_pulses", tv_cnt - tv0, 0);
        chk("idle_end_busy", int'(busy), 0);

        // Reset mid-frame discards everything.
        run_frame(1200, 0, 0, 0, 1'b1, 1'b0);
        tv0 = tv_cnt;
        frame_start = 1; tick(); frame_start = 0;
        kp_valid = 1;
        for (int i = 0; i < 50; i++) tick();
        rst = 1; tick(); rst = 0; kp_valid = 0; frame_end = 1; tick(); frame_end = 0;
        model_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mid_pulses", tv_cnt - tv0, 0);
        chk("rst_mid_th", int'(threshold), 2);
        chk("rst_mid_count", int'(last_count), 0);
        chk("rst_mid_lim", int'(at_limit), 0);
        chk("rst_mid_busy", int'(busy), 0);

        // Randomized frames against the model.
        for (int i = 0; i < 25; i++) begin
            run_frame($urandom_range(0, 1600), $urandom_range(0, 3),
                      $urandom_range(0, 2500), $urandom_range(0, 2500),
                      ($urandom_range(0, 4) != 0), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
